chn_burst_merger: RTL

Parametrised N-channel acquisition merger between the per-channel ADC data paths and the USB external FIFO. Each channel writes into its own synchronous FIFO. A round-robin arbiter drains one fixed-length burst at a time from a channel that has at least a full burst buffered, and writes it to the USB external FIFO. It honours external-FIFO backpressure, flags per-channel overflow, and can optionally prefix each burst with a channel header word.

---
 rtl/chn_burst_merger_pkg.sv | 18 +
 rtl/chn_burst_merger_if.sv | 23 ++
 rtl/chn_burst_merger_sync_fifo.sv | 58 +++++
 rtl/chn_burst_merger.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/chn_burst_merger_pkg.sv
// Shared types for the channel burst merger: arbiter state encoding and header layout.
package chn_merger_pkg;

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BURST = 2'd2,
        ST_NEXT  = 2'd3
    } merger_state_e;

    localparam logic [3:0] HDR_MARK = 4'hA;

    // Upper byte of a header word; the sequence count fills the remaining low bits.
    function automatic logic [7:0] hdr_field(input logic [3:0] chn);
        return {HDR_MARK, chn};
    endfunction

endpackage

// File: rtl/chn_burst_merger_if.sv
// Channel-side write bus and USB external-FIFO side bus of the burst merger.
interface chn_burst_merger_if #(
    parameter int NUM_CHN = 2,
    parameter int DATA_W  = 16
);
    logic [NUM_CHN*DATA_W-1:0] chn_dataout;
    logic [NUM_CHN-1:0]        chn_dataout_en;
    logic                      usb_ext_fifo_full;
    logic [DATA_W-1:0]         out_to_usb_ext_fifo_din;
    logic                      out_to_usb_ext_fifo_en;
    logic [NUM_CHN-1:0]        chn_overflow;
    logic [3:0]                cur_chn;

    modport master (
        output chn_dataout, chn_dataout_en, usb_ext_fifo_full,
        input  out_to_usb_ext_fifo_din, out_to_usb_ext_fifo_en, chn_overflow, cur_chn
    );

    modport slave (
        input  chn_dataout, chn_dataout_en, usb_ext_fifo_full,
        output out_to_usb_ext_fifo_din, out_to_usb_ext_fifo_en, chn_overflow, cur_chn
    );
endinterface

// File: rtl/chn_burst_merger_sync_fifo.sv
// First-word-fall-through synchronous FIFO with fill count and synchronous clear.
module chn_sync_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2048
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clr,
    input  logic                              wrreq,
    input  logic [DATA_W-1:0]                 data,
    input  logic                              rdreq,
    output logic [DATA_W-1:0]                 q,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH):0]       usedw
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]     usedw_q, usedw_d;
    logic              wr, rd;

    assign full  = (usedw_q == UW'(FIFO_DEPTH));
    assign empty = (usedw_q == '0);
    assign q     = mem_q[rd_ptr_q];
    assign usedw = usedw_q;

    always_comb begin
        wr       = wrreq & ~full & ~clr;
        rd       = rdreq & ~empty & ~clr;
        wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        usedw_d  = usedw_q + UW'(wr) - UW'(rd);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
        end
    end
endmodule

// File: rtl/chn_burst_merger.sv
// N-channel round-robin burst merger into the USB external FIFO.
// Define CHN_MERGER_HEADER_EN to prefix each burst with a channel/sequence header word.
module chn_burst_merger
    import chn_merger_pkg::*;
#(
    parameter int NUM_CHN    = 2,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2048,
    parameter int BURST_LEN  = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rst_all_fifo,
    chn_burst_merger_if.slave  bus
);
    localparam int CW  = $clog2(NUM_CHN);
    localparam int UW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(BURST_LEN + 1);

    logic [NUM_CHN-1:0][DATA_W-1:0] fifo_q;
    logic [NUM_CHN-1:0][UW-1:0]     fifo_usedw;
    logic [NUM_CHN-1:0]             fifo_empty, fifo_full;

    merger_state_e      state_q, state_d;
    logic [CW-1:0]      ptr_q, ptr_d, ptr_nxt;
    logic [BCW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               en_q, en_d;
    logic [NUM_CHN-1:0] ovf_q, ovf_d;
    logic               pop;
`ifdef CHN_MERGER_HEADER_EN
    localparam int SEQ_W = DATA_W - 8;
    logic [SEQ_W-1:0]   seq_q [NUM_CHN];
    logic [SEQ_W-1:0]   seq_d [NUM_CHN];
`endif

    // Writes in the clear cycle are blocked so they neither land nor flag overflow.
    for (genvar k = 0; k < NUM_CHN; k++) begin : g_chn
        chn_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (rst_all_fifo),
            .wrreq   (bus.chn_dataout_en[k] & ~rst_all_fifo),
            .data    (bus.chn_dataout[k*DATA_W +: DATA_W]),
            .rdreq   (pop && (ptr_q == CW'(k))),
            .q       (fifo_q[k]),
            .empty   (fifo_empty[k]),
            .full    (fifo_full[k]),
            .usedw   (fifo_usedw[k])
        );
    end

    assign ptr_nxt = (ptr_q == CW'(NUM_CHN - 1)) ? '0 : ptr_q + CW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        en_d    = 1'b0;
        pop     = 1'b0;
        ovf_d   = ovf_q | (bus.chn_dataout_en & fifo_full);
`ifdef CHN_MERGER_HEADER_EN
        seq_d   = seq_q;
`endif
        if (rst_all_fifo) begin
            state_d = ST_SCAN;
            ptr_d   = '0;
            cnt_d   = '0;
            dout_d  = '0;
            ovf_d   = '0;
`ifdef CHN_MERGER_HEADER_EN
            seq_d   = '{default: '0};
`endif
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (fifo_usedw[ptr_q] >= UW'(BURST_LEN)) begin
                        cnt_d = '0;
`ifdef CHN_MERGER_HEADER_EN
                        state_d = ST_HDR;
`else
                        state_d = ST_BURST;
`endif
                    end else begin
                        ptr_d = ptr_nxt;
                    end
                end
`ifdef CHN_MERGER_HEADER_EN
                ST_HDR: begin
                    if (!bus.usb_ext_fifo_full) begin
                        en_d    = 1'b1;
                        dout_d  = {hdr_field(4'(ptr_q)), seq_q[ptr_q]};
                        state_d = ST_BURST;
                    end
                end
`endif
                ST_BURST: begin
                    // Full gates the pop directly, so at most one word trails its rise.
                    if (!bus.usb_ext_fifo_full && !fifo_empty[ptr_q]) begin
                        pop    = 1'b1;
                        en_d   = 1'b1;
                        dout_d = fifo_q[ptr_q];
                        cnt_d  = cnt_q + BCW'(1);
                        if (cnt_q == BCW'(BURST_LEN - 1)) state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    ptr_d   = ptr_nxt;
`ifdef CHN_MERGER_HEADER_EN
                    seq_d[ptr_q] = seq_q[ptr_q] + SEQ_W'(1);
`endif
                    state_d = ST_SCAN;
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SCAN;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            en_q    <= 1'b0;
            ovf_q   <= '0;
`ifdef CHN_MERGER_HEADER_EN
            seq_q   <= '{default: '0};
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
`ifdef CHN_MERGER_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign bus.out_to_usb_ext_fifo_din = dout_q;
    assign bus.out_to_usb_ext_fifo_en  = en_q;
    assign bus.chn_overflow            = ovf_q;
    assign bus.cur_chn                 = 4'(ptr_q);
endmodule
